xor2_rr_arbiter: RTL and testbench

- Shares one W-bit 2-input XOR datapath between NREQ requesters in the decoder front end.
- Requesters present operand pairs with a request line. A round-robin arbiter picks one per cycle and computes a XOR b.
- The result goes into a single output register with a valid/ready handshake toward the syndrome logic, tagged with the requester ID.

---
 rtl/xor2_rr_arbiter.sv | 110 +++++++++++
 tb/tb_xor2_rr_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/xor2_rr_arbiter.sv
// xor2_rr_arbiter
// Round-robin arbiter in front of one shared W-bit XOR datapath. NREQ
// requesters present operand pairs; one winner per cycle has its a^b result
// loaded into a single output register. That register is drained toward the
// syndrome logic over a valid/ready handshake and is tagged with the
// winner's ID.
//
// The grant depends combinationally on out_ready. A new result may be loaded
// on the same edge that the old one is delivered, so the block sustains one
// result per cycle.

module xor2_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [IDW-1:0]    out_id,
    input  logic              out_ready
);

    // Round-robin pointer and the output result register.
    logic [IDW-1:0] r_ptr;
    logic           r_valid;
    logic [W-1:0]   r_data;
    logic [IDW-1:0] r_id;

    // Two-pass priority search: "hi" only considers requesters at or above
    // the pointer, and "lo" considers every requester. Falling back to lo when
    // hi is empty gives the wrap-around scan.
    logic           w_hiFound;
    logic           w_loFound;
    logic [IDW-1:0] w_hiIdx;
    logic [IDW-1:0] w_loIdx;
    logic [W-1:0]   w_hiXor;
    logic [W-1:0]   w_loXor;

    logic [IDW-1:0] w_winner;
    logic [W-1:0]   w_winXor;
    logic [IDW-1:0] w_nextPtr;
    logic           w_accept;
    logic [NREQ-1:0] w_gnt;

    // Scan from the highest index down, so the last hit is the lowest index.
    // The XOR for each candidate is taken with a constant slice.
    always_comb begin
        w_hiFound = 1'b0;
        w_loFound = 1'b0;
        w_hiIdx   = '0;
        w_loIdx   = '0;
        w_hiXor   = '0;
        w_loXor   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_loFound = 1'b1;
                w_loIdx   = IDW'(i);
                w_loXor   = a_in[i*W +: W] ^ b_in[i*W +: W];
                if (i >= int'(r_ptr)) begin
                    w_hiFound = 1'b1;
                    w_hiIdx   = IDW'(i);
                    w_hiXor   = a_in[i*W +: W] ^ b_in[i*W +: W];
                end
            end
        end
    end

    // Pick the winner and decide whether the output register can take a new
    // result this cycle. Reset suppresses every grant.
    always_comb begin
        w_winner  = w_hiFound ? w_hiIdx : w_loIdx;
        w_winXor  = w_hiFound ? w_hiXor : w_loXor;
        w_accept  = w_loFound && (!r_valid || out_ready) && !reset;
        w_nextPtr = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);
        w_gnt     = '0;
        if (w_accept) begin
            w_gnt[w_winner] = 1'b1;
        end
    end

    // Result register and pointer. A new winner overwrites the register, even
    // on a drain edge. The pointer only moves on an accepted grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
        end else if (w_accept) begin
            r_ptr   <= w_nextPtr;
            r_valid <= 1'b1;
            r_data  <= w_winXor;
            r_id    <= w_winner;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign gnt       = w_gnt;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_id    = r_id;

endmodule

// File: tb/tb_xor2_rr_arbiter.sv
// tb_xor2_rr_arbiter
// Directed scenarios followed by randomized traffic. A behavioural model
// predicts grants and pushes the expected results into a queue. A separate
// monitor compares whatever the DUT presents against the head of that queue.

module tb_xor2_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 2;
    localparam int IDW  = 2;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [IDW-1:0]    out_id;
    logic              out_ready;

    int checks;
    int fails;

    // Model state: the pointer, the occupancy of the result register, and the
    // queue of expected {id, data} results that have not been delivered yet.
    int mPtr;
    bit mValid;
    bit lastReset;
    int expQ[$];

    xor2_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .gnt      (gnt),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict this cycle's grant from the stable inputs and the model state,
    // check the grant, then advance the model to its state after the edge.
    task automatic modelStep();
        int winner;
        int expGnt;
        bit accept;
        int av;
        int bv;
        if (lastReset) begin
            checkOutput("resetValid", int'(out_valid), 0);
            checkOutput("resetData", int'(out_data), 0);
            checkOutput("resetId", int'(out_id), 0);
        end else begin
            checkOutput("outValid", int'(out_valid), int'(mValid));
        end
        winner = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (mPtr + k) % NREQ;
            if (winner < 0 && req[idx]) winner = idx;
        end
        accept = (winner >= 0) && (!mValid || out_ready) && !reset;
        expGnt = accept ? (1 << winner) : 0;
        checkOutput("gnt", int'(gnt), expGnt);
        if (reset) begin
            expQ.delete();
            mValid = 0;
            mPtr = 0;
        end else if (accept) begin
            av = (int'(a_in) >> (winner * W)) & ((1 << W) - 1);
            bv = (int'(b_in) >> (winner * W)) & ((1 << W) - 1);
            expQ.push_back((winner << W) | (av ^ bv));
            mValid = 1;
            mPtr = (winner + 1) % NREQ;
        end else if (mValid && out_ready) begin
            mValid = 0;
        end
        lastReset = reset;
    endtask

    // Drive one cycle of inputs just after the falling edge, then run the model.
    task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] rq,
                                 input logic [NREQ*W-1:0] a, input logic [NREQ*W-1:0] b,
                                 input logic rdy);
        @(negedge clk);
        reset = rst;
        req = rq;
        a_in = a;
        b_in = b;
        out_ready = rdy;
        #1;
        modelStep();
    endtask

    // Monitor: whenever a result is presented, it must match the oldest
    // undelivered expectation. That result is retired when out_ready is high.
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("resultUnexpected", 1, 0);
            end else begin
                checkOutput("outId", int'(out_id), expQ[0] >> W);
                checkOutput("outData", int'(out_data), expQ[0] & ((1 << W) - 1));
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rrExp [5];
        checks = 0;
        fails = 0;
        mPtr = 0;
        mValid = 0;
        lastReset = 0;
        reset = 1'b1;
        req = '0;
        a_in = '0;
        b_in = '0;
        out_ready = 1'b0;

        // Reset held for two cycles while every requester is asking.
        applyStimulus(1'b1, 4'b1111, 8'hA5, 8'h3C, 1'b1);
        applyStimulus(1'b1, 4'b1111, 8'hA5, 8'h3C, 1'b1);
        checkOutput("gntDuringReset", int'(gnt), 0);
        applyStimulus(1'b0, 4'b1111, 8'hA5, 8'h3C, 1'b1);
        checkOutput("firstGnt", int'(gnt), 4'b0001);

        // Single requester 2: 10 ^ 11 = 01.
        applyStimulus(1'b0, 4'b0100, 8'b0010_0000, 8'b0011_0000, 1'b1);
        checkOutput("singleGnt", int'(gnt), 4'b0100);
        applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00, 1'b1);
        checkOutput("singleValid", int'(out_valid), 1);
        checkOutput("singleData", int'(out_data), 2'b01);
        checkOutput("singleId", int'(out_id), 2);

        // Round robin with all requesters active, starting from a fresh pointer.
        applyStimulus(1'b1, 4'b0000, 8'h00, 8'h00, 1'b1);
        rrExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b1111, 8'b11_10_01_00, 8'hFF, 1'b1);
            checkOutput($sformatf("rrGnt%0d", i), int'(gnt), int'(rrExp[i]));
        end

        // Backpressure: a pending result with out_ready low blocks new grants.
        applyStimulus(1'b0, 4'b0011, 8'h5A, 8'h0F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'b0011, 8'h5A, 8'h0F, 1'b0);
            checkOutput($sformatf("bpGnt%0d", i), int'(gnt), 0);
        end
        applyStimulus(1'b0, 4'b0011, 8'h5A, 8'h0F, 1'b1);
        checkOutput("bpResumeValid", int'(out_valid), 1);

        // Pointer skip and wrap.
        applyStimulus(1'b0, 4'b1000, 8'hC3, 8'h96, 1'b1);
        checkOutput("wrapGnt3", int'(gnt), 4'b1000);
        applyStimulus(1'b0, 4'b0110, 8'hC3, 8'h96, 1'b1);
        checkOutput("skipGnt1", int'(gnt), 4'b0010);
        applyStimulus(1'b0, 4'b0100, 8'hC3, 8'h96, 1'b1);
        checkOutput("skipGnt2", int'(gnt), 4'b0100);
        applyStimulus(1'b0, 4'b0001, 8'hC3, 8'h96, 1'b1);
        checkOutput("wrapGnt0", int'(gnt), 4'b0001);

        // Mid-operation reset discards the pending result and the pointer.
        applyStimulus(1'b0, 4'b0010, 8'h24, 8'h81, 1'b1);
        applyStimulus(1'b1, 4'b0000, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b0, 4'b1100, 8'h9C, 8'h33, 1'b1);
        checkOutput("midResetValid", int'(out_valid), 0);
        checkOutput("midResetGnt", int'(gnt), 4'b0100);

        // Randomized traffic, with random backpressure and occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          NREQ'($urandom), (NREQ*W)'($urandom), (NREQ*W)'($urandom),
                          ($urandom_range(0, 3) != 0));
        end

        // Drain whatever is left, then the expectation queue must be empty.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 4'b0000, 8'h00, 8'h00, 1'b1);
        end
        @(negedge clk);
        #3;
        checkOutput("queueDrained", expQ.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
